seg_scan_driver: RTL and testbench

Parametrised, self-scanning multiplexed 7-segment display driver for the board's common-anode displays. It owns its own digit-scan prescaler instead of taking an external scan index. It double-buffers display data so frames never tear. It adds per-digit blinking, 16-level PWM brightness and a lamp test. It sits between application logic (hex value, enables, decimal points) and the `seg`/`an` pins.

---
 rtl/seg_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Self-scanning multiplexed 7-segment driver for common-anode displays.
// Owns the digit-scan prescaler, double-buffers frame data, and adds blink, PWM dimming and lamp test.
module seg_scan_driver #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     le,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blink,
    input  logic [3:0]            brightness,
    input  logic                  lamp_test,
    output logic                  pending,
    output logic                  frame,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned PC_W      = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SLOT_STEP = SCAN_DIV / 16;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   le;
        logic [DIGITS-1:0]   point;
        logic [DIGITS-1:0]   blink;
    } frame_buf_t;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BC_W-1:0]  bc_q, bc_d;
    logic             phase_q, phase_d;
    logic             pending_q, pending_d;
    frame_buf_t       stg_q, stg_d;
    frame_buf_t       dsp_q, dsp_d;
    logic [7:0]       seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic             frame_q, frame_d;

    logic             tick;
    logic             commit;
    frame_buf_t       load_buf;

    assign tick     = (pc_q == PC_LAST);
    assign commit   = tick && (idx_q == IDX_LAST);
    assign load_buf = '{data: data, le: le, point: point, blink: blink};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan timing, blink phase and buffer handoff
    always_comb begin
        pc_d      = tick ? '0 : pc_q + 1'b1;
        idx_d     = idx_q;
        bc_d      = bc_q;
        phase_d   = phase_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (commit) begin
            if (bc_q == BC_LAST) begin
                bc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end
        // A load coincident with the commit keeps pending set for the next frame.
        pending_d = load | (pending_q & ~commit);
        stg_d     = load ? load_buf : stg_q;
        dsp_d     = (commit && pending_q) ? stg_q : dsp_q;
    end

    // Per-digit views with digit 0 = leftmost (MS nibble, MS enable bit).
    logic [3:0] dig_nib   [DIGITS];
    logic       dig_le    [DIGITS];
    logic       dig_point [DIGITS];
    logic       dig_blink [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign dig_nib[gi]   = dsp_q.data[4*(DIGITS-1-gi) +: 4];
        assign dig_le[gi]    = dsp_q.le[DIGITS-1-gi];
        assign dig_point[gi] = dsp_q.point[DIGITS-1-gi];
        assign dig_blink[gi] = dsp_q.blink[DIGITS-1-gi];
    end

    logic [31:0] pwm_limit;
    logic        pwm_on;
    logic        lit;
    logic        drive;

    assign pwm_limit = (32'(brightness) + 32'd1) * 32'(SLOT_STEP);
    assign pwm_on    = (32'(pc_q) < pwm_limit);
    assign lit       = lamp_test | (dig_le[idx_q] & ~(dig_blink[idx_q] & phase_q));
    assign drive     = lit & pwm_on;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
        assign an_d[DIGITS-1-gi] = ~(drive && (idx_q == IDX_W'(gi)));
    end

    always_comb begin
        seg_d   = lamp_test ? 8'h00 : {~dig_point[idx_q], hex_to_seg(dig_nib[idx_q])};
        frame_d = (pc_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            idx_q     <= '0;
            bc_q      <= '0;
            phase_q   <= 1'b0;
            pending_q <= 1'b0;
            stg_q     <= '0;
            dsp_q     <= '0;
            seg_q     <= 8'hFF;
            an_q      <= '1;
            frame_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            idx_q     <= idx_d;
            bc_q      <= bc_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            stg_q     <= stg_d;
            dsp_q     <= dsp_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign pending = pending_q;
    assign frame   = frame_q;
    assign seg     = seg_q;
    assign an      = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised and directed bench for seg_scan_driver; expected outputs come from a
// cycle-count based reference model of the scan, commit and blink rules.
module tb_seg_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 16;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  le = '0;
    logic [3:0]  point = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  brightness = 4'd15;
    logic        lamp_test = 1'b0;
    logic        pending;
    logic        frame;
    logic [7:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    // Reference model state: t counts cycles since reset release.
    int          t;
    logic [15:0] m_stg_data, m_dsp_data;
    logic [3:0]  m_stg_le, m_dsp_le, m_stg_point, m_dsp_point, m_stg_blink, m_dsp_blink;
    bit          m_pending;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .le         (le),
        .point      (point),
        .blink      (blink),
        .brightness (brightness),
        .lamp_test  (lamp_test),
        .pending    (pending),
        .frame      (frame),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_stg_data = '0; m_stg_le = '0; m_stg_point = '0; m_stg_blink = '0;
        m_dsp_data = '0; m_dsp_le = '0; m_dsp_point = '0; m_dsp_blink = '0;
        m_pending = 1'b0;
    endtask

    // One clock: predict the registered outputs from this cycle, advance the model, compare.
    task automatic cycle();
        int pc, idx, pos, phase;
        bit lit, on;
        logic [3:0] nib;
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
        bit exp_frame;
        pc    = t % SCAN_DIV;
        idx   = (t / SCAN_DIV) % DIGITS;
        phase = ((t / FRAME_LEN) / BLINK_FRAMES) % 2;
        pos   = DIGITS - 1 - idx;
        lit   = lamp_test || (m_dsp_le[pos] && !(m_dsp_blink[pos] && phase == 1));
        on    = pc < (int'(brightness) + 1) * (SCAN_DIV / 16);
        exp_an    = (lit && on) ? (4'hF & ~(4'b0001 << pos)) : 4'hF;
        nib       = m_dsp_data[pos*4 +: 4];
        exp_seg   = lamp_test ? 8'h00 : {~m_dsp_point[pos], seg_tab[nib]};
        exp_frame = (t % FRAME_LEN) == 0;
        if ((t % FRAME_LEN) == FRAME_LEN - 1) begin
            if (m_pending) begin
                m_dsp_data = m_stg_data; m_dsp_le = m_stg_le;
                m_dsp_point = m_stg_point; m_dsp_blink = m_stg_blink;
            end
            m_pending = 1'b0;
        end
        if (load) begin
            m_stg_data = data; m_stg_le = le; m_stg_point = point; m_stg_blink = blink;
            m_pending = 1'b1;
        end
        t++;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("seg", seg, exp_seg);
        check("an", {4'h0, an}, {4'h0, exp_an});
        check("frame", {7'h0, frame}, {7'h0, exp_frame});
        check("pending", {7'h0, pending}, {7'h0, m_pending});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until(input int pos_in_frame);
        while ((t % FRAME_LEN) != pos_in_frame) cycle();
    endtask

    task automatic stage(input logic [15:0] d, input logic [3:0] l, input logic [3:0] p,
                         input logic [3:0] b);
        data = d; le = l; point = p; blink = b; load = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_seg", seg, 8'hFF);
            check("rst_an", {4'h0, an}, 8'h0F);
            check("rst_pending", {7'h0, pending}, 8'h00);
            check("rst_frame", {7'h0, frame}, 8'h00);
        end
        rst = 1'b0;
        model_reset();
        run(FRAME_LEN + 6);

        // Load/commit of the reference pattern at full brightness
        stage(16'h1A3F, 4'hF, 4'b0010, 4'h0);
        cycle();
        run(2 * FRAME_LEN + 3);

        // Coincident load on the commit edge
        run_until(10);
        stage(16'h2222, 4'hF, 4'h0, 4'h0);
        cycle();
        run_until(FRAME_LEN - 1);
        stage(16'h7777, 4'hF, 4'h0, 4'h0);
        cycle();
        run(2 * FRAME_LEN);

        // PWM duty levels
        brightness = 4'd3;
        run(FRAME_LEN);
        brightness = 4'd0;
        run(FRAME_LEN);
        brightness = 4'd15;

        // Blink on the leftmost digit over several blink periods
        stage(16'h8421, 4'hF, 4'h0, 4'b1000);
        cycle();
        run(5 * FRAME_LEN);

        // Lamp test with all digits disabled
        stage(16'h0000, 4'h0, 4'h0, 4'h0);
        cycle();
        run(FRAME_LEN);
        lamp_test = 1'b1;
        run(FRAME_LEN + 5);
        lamp_test = 1'b0;
        run(3);

        // Randomised loads, brightness and lamp-test activity
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 39) == 0)
                stage(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 149) == 0) lamp_test = ~lamp_test;
            cycle();
        end
        lamp_test = 1'b0;
        brightness = 4'd15;

        // Asynchronous reset mid-slot with data pending
        stage(16'h5A5A, 4'hF, 4'hF, 4'h0);
        cycle();
        run(7);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_an", {4'h0, an}, 8'h0F);
        check("mid_rst_seg", seg, 8'hFF);
        check("mid_rst_pending", {7'h0, pending}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run(FRAME_LEN + 4);
        stage(16'hC0DE, 4'hF, 4'b0101, 4'h0);
        cycle();
        run(2 * FRAME_LEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
